if_id_skid_stage: RTL
=====================

// Module: if_id_skid_stage
// PURPOSE
//  Parametrised IF/ID pipeline stage with valid/ready handshake, 2-entry skid storage,
//  synchronous flush and async reset. Sits between fetch and decode: takes {pc, inst}
//  from fetch, presents it to decode one cycle later. Backpressure stalls fetch
//  without a combinational ready path.
//  Replaces the free-running IF/ID latch pair with a single-edge (posedge) design.
// PARAMETERS
//  PC_W      32            width of program-counter field
//  INST_W    32            width of instruction field
//  NOP_INST  32'h0000_0000 instruction value driven when stage is empty/flushed
//  RESET_PC  32'h0000_0000 out_pc value after reset/flush
// PORTS
//  clk        in   1       single clock, all state updates on posedge
//  rst        in   1       asynchronous, active-high reset
//  flush      in   1       synchronous flush (branch taken / exception)
//  in_valid   in   1       fetch presents valid {in_pc,in_inst}
//  in_ready   out  1       stage can accept; registered (= !skid_valid)
//  in_pc      in   PC_W    fetched PC
//  in_inst    in   INST_W  fetched instruction
//  out_valid  out  1       decode payload valid
//  out_ready  in   1       decode accepts this cycle
//  out_pc     out  PC_W    registered PC to decode
//  out_inst   out  INST_W  registered instruction to decode
//  occupancy  out  2       entries held: 0,1,2
// BEHAVIOUR
//  Reset (async, rst=1): out_valid=0, skid_valid=0, in_ready=1, out_pc=RESET_PC,
//   out_inst=NOP_INST, occupancy=0; skid payload cleared to RESET_PC/NOP_INST.
//  in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  Latency: 1 cycle in_fire -> out_valid when main slot empty or draining.
//  Slots: MAIN drives outputs directly; SKID holds one overflow entry.
//  Per posedge, priority order:
//   1 flush: out_valid=0, skid_valid=0, out_pc=RESET_PC, out_inst=NOP_INST;
//     input in same cycle is dropped (not captured even if in_fire).
//   2 skid full & out_fire: MAIN<=SKID, SKID empties (in_ready=0, so no in_fire).
//   3 MAIN empty | out_fire: MAIN<=input if in_fire, else out_valid=0 and
//     out_inst=NOP_INST, out_pc holds.
//   4 MAIN full & !out_ready & in_fire: SKID<=input, skid_valid=1.
//  Hold rule: out_valid & !out_ready -> out_pc/out_inst/out_valid unchanged.
//  States (occupancy): EMPTY(0) -in_fire-> ONE(1); ONE -stall&in_fire-> FULL(2);
//   ONE -out_fire&!in_fire-> EMPTY; ONE -out_fire&in_fire-> ONE (new payload);
//   FULL -out_fire-> ONE; any -flush-> EMPTY. occupancy == {skid_valid, out_valid^skid_valid}
//   encoding as 0/1/2; value 3 illegal (assert).
//  No data loss/duplication: every in_fire not cancelled by flush yields exactly
//   one out_fire, in order.
//  in_valid with in_ready=0: ignored, fetch must hold payload (not checked here).
//  rst asserted mid-transfer: all entries discarded immediately, no partial update.
// STRUCTURE
//  Package if_id_pkg: PC_W/INST_W defaults, NOP_INST, RESET_PC, occupancy encodings
//   (OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_FULL=2'd2).
//  Sub-module pipe_slot: one valid+payload register with load/clear inputs,
//   instantiated twice (MAIN, SKID); top holds the steering/priority logic.
// TESTING
//  T1 reset: rst=1 mid-stream -> out_valid=0, out_inst=NOP_INST, in_ready=1, occ=0.
//  T2 flow: out_ready=1, feed pc 0x0,0x4,0x8 b2b -> same seq on out 1 cycle later, occ=1.
//  T3 stall: out_ready=0 after pc=0x10 captured, send pc=0x14 -> occ=2, in_ready=0,
//   out_pc holds 0x10; release out_ready -> 0x10 then 0x14, in_ready=1 cycle later.
//  T4 flush: occ=2 (0x20,0x24), flush=1 with in_valid pc=0x28 -> occ=0, out_valid=0,
//   0x28 never appears; next in_fire pc=0x40 is next output.
//  T5 simultaneous: occ=1, out_fire & in_fire same cycle -> occ stays 1, new payload out.
//  T6 random: random in_valid/out_ready/flush (5%) 10k cycles, scoreboard order/no loss.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared defaults and occupancy encodings for the IF/ID skid stage.
package if_id_pkg;

  localparam int          DEF_PC_W     = 32;
  localparam int          DEF_INST_W   = 32;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // skid can only be valid behind a valid main slot, so 3 never encodes
  function automatic logic [1:0] occ_encode(input logic skid_vld, input logic main_vld);
    return {skid_vld, main_vld ^ skid_vld};
  endfunction

endpackage

// File: rtl/if_id_skid_stage_pipe_slot.sv
// One valid+payload register. clear wipes everything; drop invalidates, blanks
// the instruction to NOP but keeps the PC so decode still sees the last address.
module pipe_slot #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              drop,
  input  logic              load,
  input  logic [PC_W-1:0]   load_pc,
  input  logic [INST_W-1:0] load_inst,
  output logic              vld,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      pc   <= RESET_PC;
      inst <= NOP_INST;
    end else if (clear) begin
      vld  <= 1'b0;
      pc   <= RESET_PC;
      inst <= NOP_INST;
    end else if (load) begin
      vld  <= 1'b1;
      pc   <= load_pc;
      inst <= load_inst;
    end else if (drop) begin
      vld  <= 1'b0;
      inst <= NOP_INST;
    end
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID stage: MAIN slot drives decode, SKID absorbs one entry under stall.
// in_ready is registered (!skid_valid) so decode stalls never reach fetch combinationally.
module if_id_skid_stage
  import if_id_pkg::*;
#(
  parameter int                PC_W     = DEF_PC_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST,
  parameter logic [PC_W-1:0]   RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy
);

  logic              main_vld, skid_vld;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;

  logic              main_clr, main_drop, main_load;
  logic              skid_clr, skid_load;
  logic [PC_W-1:0]   main_ld_pc;
  logic [INST_W-1:0] main_ld_inst;
  logic              in_fire, out_fire;

  assign in_ready  = !skid_vld;
  assign out_valid = main_vld;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_vld & out_ready;
  assign occupancy = occ_encode(skid_vld, main_vld);

  always_comb begin
    main_clr     = 1'b0;
    main_drop    = 1'b0;
    main_load    = 1'b0;
    skid_clr     = 1'b0;
    skid_load    = 1'b0;
    main_ld_pc   = in_pc;
    main_ld_inst = in_inst;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (skid_vld && out_fire) begin
      main_load    = 1'b1;
      main_ld_pc   = skid_pc;
      main_ld_inst = skid_inst;
      skid_clr     = 1'b1;
    end else if (!main_vld || out_fire) begin
      main_load = in_fire;
      main_drop = !in_fire;
    end else if (in_fire) begin
      // main is stalled, overflow lands in skid
      skid_load = 1'b1;
    end
  end

  pipe_slot #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) u_main (
    .clk      (clk),
    .rst      (rst),
    .clear    (main_clr),
    .drop     (main_drop),
    .load     (main_load),
    .load_pc  (main_ld_pc),
    .load_inst(main_ld_inst),
    .vld      (main_vld),
    .pc       (out_pc),
    .inst     (out_inst)
  );

  pipe_slot #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clear    (skid_clr),
    .drop     (1'b0),
    .load     (skid_load),
    .load_pc  (in_pc),
    .load_inst(in_inst),
    .vld      (skid_vld),
    .pc       (skid_pc),
    .inst     (skid_inst)
  );

  always_ff @(posedge clk) begin
    if (!rst) assert (occupancy <= OCC_FULL);
  end

endmodule
